dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 143 ++++++++++++++
 tb/tb_dm_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: word-addressed data memory with byte-lane writes.
// Writes pass through a one-entry write buffer so the array sees at most
// one write per cycle while reads still see the newest data. Reads are
// registered with a fixed one-cycle latency.

module dm_responder #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [3:0]        DM_write_en,
  input  logic [31:0]       DM_data_in,
  output logic [31:0]       data_from_mem,
  output logic              wb_pending,
  output logic [15:0]       wr_count
);

  // Index width of the storage array; at least one bit so tiny depths elaborate.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Depth as an ADDR_W+1 bit value so the range test is width-matched.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  // Overlay the lanes selected by mask from upper onto base.
  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] upper,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = upper[8*i +: 8];
    end
    return res;
  endfunction

  // Storage array; deliberately has no reset.
  logic [31:0] mem_q [DEPTH];

  // Write buffer state.
  logic              buf_vld_q,  buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [3:0]        buf_mask_q, buf_mask_d;

  // Read pipeline and write counter.
  logic [31:0]       rd_data_q, rd_data_d;
  logic [15:0]       wr_cnt_q,  wr_cnt_d;

  // Decoded request.
  logic              in_range;
  logic              wr_cycle;
  logic              wr_acc;
  logic              buf_hit;
  logic              commit;
  logic [3:0]        new_mask;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  buf_idx;
  logic [31:0]       arr_word;

  assign in_range = ({1'b0, DM_addr} < DEPTH_C);
  assign wr_cycle = (DM_write_en != 4'b1111);
  // Writes outside the array are dropped and behave like an idle cycle.
  assign wr_acc   = wr_cycle && in_range;
  assign new_mask = ~DM_write_en;
  assign buf_hit  = buf_vld_q && (buf_addr_q == DM_addr);
  assign rd_idx   = DM_addr[IDX_W-1:0];
  assign buf_idx  = buf_addr_q[IDX_W-1:0];
  assign arr_word = mem_q[rd_idx];

  // Write-buffer next state: load, coalesce, or drain into the array.
  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    commit     = 1'b0;
    if (wr_acc) begin
      if (buf_hit) begin
        // Same word still buffered: fold the new lanes in, nothing reaches the array.
        buf_data_d = merge_lanes(buf_data_q, DM_data_in, new_mask);
        buf_mask_d = buf_mask_q | new_mask;
      end else begin
        // Retire whatever was buffered and take the new write in the same edge.
        commit     = buf_vld_q;
        buf_addr_d = DM_addr;
        buf_data_d = DM_data_in;
        buf_mask_d = new_mask;
      end
      buf_vld_d = 1'b1;
    end else begin
      // Idle cycle: the array port is free, so drain the buffer.
      commit    = buf_vld_q;
      buf_vld_d = 1'b0;
    end
  end

  // Read data and write counter next state; reads see the pre-edge buffer.
  always_comb begin
    rd_data_d = 32'd0;
    if (in_range) begin
      rd_data_d = buf_hit ? merge_lanes(arr_word, buf_data_q, buf_mask_q) : arr_word;
    end
    wr_cnt_d = wr_cnt_q;
    if (wr_acc && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      rd_data_q <= 32'd0;
      wr_cnt_q  <= 16'd0;
    end else begin
      buf_vld_q <= buf_vld_d;
      rd_data_q <= rd_data_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Buffer payload; meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
    buf_mask_q <= buf_mask_d;
  end

  // Array update: only the buffered lanes of a committing entry are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_mask_q[i]) mem_q[buf_idx][8*i +: 8] <= buf_data_q[8*i +: 8];
      end
    end
  end

  assign data_from_mem = rd_data_q;
  assign wb_pending    = buf_vld_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  localparam int AW  = 14;
  localparam int DEP = 1024;

  logic          clk;
  logic          rst;
  logic [AW-1:0] DM_addr;
  logic [3:0]    DM_write_en;
  logic [31:0]   DM_data_in;
  logic [31:0]   data_from_mem;
  logic          wb_pending;
  logic [15:0]   wr_count;

  int checks = 0;
  int errors = 0;

  dm_responder #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk           (clk),
    .rst           (rst),
    .DM_addr       (DM_addr),
    .DM_write_en   (DM_write_en),
    .DM_data_in    (DM_data_in),
    .data_from_mem (data_from_mem),
    .wb_pending    (wb_pending),
    .wr_count      (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory as seen by any later read, plus the undo record
  // of the newest not-yet-retired write run so a reset can discard it.
  logic [31:0] mm [0:DEP-1];
  bit          m_pend;
  int          m_pend_addr;
  logic [31:0] m_pend_saved;
  int          m_cnt;

  task automatic model_cycle(input logic [AW-1:0] a, input logic [3:0] we,
                             input logic [31:0] d, output logic [31:0] exp_rd);
    int  ai;
    bit  inr;
    ai  = int'(a);
    inr = (ai < DEP);
    exp_rd = inr ? mm[ai] : 32'd0;
    if ((we != 4'hF) && inr) begin
      if (!m_pend || m_pend_addr != ai) begin
        m_pend_saved = mm[ai];
        m_pend_addr  = ai;
      end
      for (int i = 0; i < 4; i++)
        if (!we[i]) mm[ai][8*i +: 8] = d[8*i +: 8];
      m_pend = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_pend = 1'b0;
    end
  endtask

  task automatic model_reset();
    if (m_pend) mm[m_pend_addr] = m_pend_saved;
    m_pend = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of traffic; optionally compare outputs with the model.
  task automatic step(input logic [AW-1:0] a, input logic [3:0] we,
                      input logic [31:0] d, input bit chk);
    logic [31:0] e;
    DM_addr     = a;
    DM_write_en = we;
    DM_data_in  = d;
    model_cycle(a, we, d, e);
    @(posedge clk); #1;
    if (chk) begin
      check("rd_data", data_from_mem, e);
      check("wb_pending", {31'd0, wb_pending}, {31'd0, m_pend});
      check("wr_count", {16'd0, wr_count}, m_cnt[31:0]);
    end
  endtask

  task automatic do_reset();
    DM_write_en = 4'hF;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   data;
    logic [31:0]   exp_rd;
    logic          exp_pend;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] dummy;
    tbl[0]  = '{14'h010, 4'b0000, 32'hDEADBEEF, 32'hA5A50010, 1'b1, 16'd1};
    tbl[1]  = '{14'h010, 4'b1111, 32'h00000000, 32'hDEADBEEF, 1'b0, 16'd1};
    tbl[2]  = '{14'h020, 4'b0000, 32'h11223344, 32'hA5A50020, 1'b1, 16'd2};
    tbl[3]  = '{14'h020, 4'b1101, 32'h0000AA00, 32'h11223344, 1'b1, 16'd3};
    tbl[4]  = '{14'h020, 4'b1111, 32'h00000000, 32'h1122AA44, 1'b0, 16'd3};
    tbl[5]  = '{14'h020, 4'b1111, 32'h00000000, 32'h1122AA44, 1'b0, 16'd3};
    tbl[6]  = '{14'h030, 4'b1100, 32'h0000BEEF, 32'hA5A50030, 1'b1, 16'd4};
    tbl[7]  = '{14'h030, 4'b0011, 32'hCAFE0000, 32'hA5A5BEEF, 1'b1, 16'd5};
    tbl[8]  = '{14'h030, 4'b1111, 32'h00000000, 32'hCAFEBEEF, 1'b0, 16'd5};
    tbl[9]  = '{14'h040, 4'b0000, 32'h00000000, 32'hA5A50040, 1'b1, 16'd6};
    tbl[10] = '{14'h040, 4'b1111, 32'h00000000, 32'h00000000, 1'b0, 16'd6};
    tbl[11] = '{14'h040, 4'b0000, 32'h55555555, 32'h00000000, 1'b1, 16'd7};
    tbl[12] = '{14'h040, 4'b1111, 32'h00000000, 32'h55555555, 1'b0, 16'd7};
    tbl[13] = '{14'h400, 4'b0000, 32'h12341234, 32'h00000000, 1'b0, 16'd7};
    tbl[14] = '{14'h400, 4'b1111, 32'h00000000, 32'h00000000, 1'b0, 16'd7};
    tbl[15] = '{14'h3FF, 4'b1111, 32'h00000000, 32'hA5A503FF, 1'b0, 16'd7};

    for (int i = 0; i < DEP; i++) mm[i] = 32'd0;
    m_pend = 1'b0; m_pend_addr = 0; m_pend_saved = 32'd0; m_cnt = 0;

    rst = 1'b1;
    DM_addr = '0; DM_write_en = 4'hF; DM_data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_data", data_from_mem, 32'd0);
    check("reset wb_pending", {31'd0, wb_pending}, 32'd0);
    check("reset wr_count", {16'd0, wr_count}, 32'd0);
    rst = 1'b0;

    // Give every word a known value, let the buffer drain, then restart counting.
    for (int i = 0; i < DEP; i++) step(i[AW-1:0], 4'b0000, 32'hA5A50000 | i, 1'b0);
    step('0, 4'hF, 32'd0, 1'b0);
    do_reset();

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      DM_addr     = tbl[i].addr;
      DM_write_en = tbl[i].we;
      DM_data_in  = tbl[i].data;
      model_cycle(tbl[i].addr, tbl[i].we, tbl[i].data, dummy);
      @(posedge clk); #1;
      check($sformatf("tbl%0d rd_data", i), data_from_mem, tbl[i].exp_rd);
      check($sformatf("tbl%0d wb_pending", i), {31'd0, wb_pending}, {31'd0, tbl[i].exp_pend});
      check($sformatf("tbl%0d wr_count", i), {16'd0, wr_count}, {16'd0, tbl[i].exp_cnt});
    end

    // Asynchronous reset with a write still buffered.
    step(14'h050, 4'b0000, 32'h12345678, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async rst rd_data", data_from_mem, 32'd0);
    check("async rst wb_pending", {31'd0, wb_pending}, 32'd0);
    check("async rst wr_count", {16'd0, wr_count}, 32'd0);
    DM_addr = 14'h050; DM_write_en = 4'b0000; DM_data_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("rst hold wr_count", {16'd0, wr_count}, 32'd0);
    check("rst hold rd_data", data_from_mem, 32'd0);
    rst = 1'b0;
    step(14'h050, 4'hF, 32'd0, 1'b1);
    check("discarded write", data_from_mem, 32'hA5A50050);

    // Randomized traffic against the model, clustered to force hits and boundary addresses.
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] a;
      logic [3:0]    we;
      a  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(1020, 1027));
      we = ($urandom_range(0, 9) < 3) ? 4'hF : 4'($urandom_range(0, 14));
      step(a, we, $urandom, 1'b1);
    end

    // Counter saturation.
    do_reset();
    for (int n = 0; n < 65536; n++) step(AW'($urandom_range(0, 7)), 4'b0000, $urandom, 1'b0);
    check("sat wr_count", {16'd0, wr_count}, 32'h0000FFFF);
    step(14'h003, 4'b0000, 32'h0BADF00D, 1'b1);
    check("sat hold wr_count", {16'd0, wr_count}, 32'h0000FFFF);
    step(14'h003, 4'hF, 32'd0, 1'b1);
    check("sat last write", data_from_mem, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
